// File: rtl/rv_pkg.sv
// Shared types and constants for the RV32I multi-cycle control path.
package rv_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    FAULT   = 3'd5
  } state_t;

  // opcode[6:2]; opcode[1:0] is always 2'b11 for 32-bit encodings
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_REG    = 5'b01100;
  localparam logic [4:0] OP_FENCE  = 5'b00011;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_IMM   = 2'b01,
    PC_ALU   = 2'b10
  } pc_sel_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } fault_cause_t;

  function automatic logic is_legal_op(input logic [6:0] op);
    logic legal;
    legal = 1'b0;
    if (op[1:0] == 2'b11) begin
      case (op[6:2])
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
        OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_FENCE: legal = 1'b1;
        default: legal = 1'b0;
      endcase
    end
    return legal;
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts wait cycles of an outstanding memory request and flags expiry
// on the last permitted cycle unless ready arrives in that same cycle.
module mem_watchdog
  import rv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  input  logic i_ready,
  output logic o_expire
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(MEM_TIMEOUT - 1);

  logic [TW-1:0] timer;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      timer <= '0;
    end else if (i_clear) begin
      timer <= '0;
    end else if (i_enable && !i_ready) begin
      timer <= timer + 1'b1;
    end
  end

  assign o_expire = i_enable && !i_ready && (timer == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I sequencer: owns the shared memory port and the
// datapath enables, with a request watchdog and a sticky fault state.
//
// state   | meaning
// FETCH   | instruction read on the memory port, IR captured on ready
// DECODE  | operands read, opcode legality checked
// EXECUTE | ALU operates; picks MEM for loads/stores, else WB
// MEM     | data access on the memory port, MDR captured on ready for loads
// WB      | register write, PC update, retire count
// FAULT   | absorbing until reset; cause held
module core_sequencer
  import rv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int COUNT_W     = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [6:0]         i_opcode,
  input  logic               i_rwrite,
  input  logic               i_mwrite,
  input  logic               i_load,
  input  logic               i_taken,
  input  logic               i_mem_ready,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic               o_addr_sel,
  output logic               o_ir_we,
  output logic               o_mdr_we,
  output logic               o_rf_we,
  output logic               o_pc_we,
  output logic [1:0]         o_pc_sel,
  output logic [COUNT_W-1:0] o_retired,
  output logic               o_fault,
  output logic [1:0]         o_fault_cause
);

  state_t       state, state_nxt;
  fault_cause_t cause, cause_nxt;
  logic         cause_load;
  logic         in_mem_phase;
  logic         expire;

  logic mem_req, mem_we, addr_sel, ir_we, mdr_we, rf_we, pc_we;
  pc_sel_t pc_sel;

  assign in_mem_phase = (state == FETCH) || (state == MEM);

  mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (!in_mem_phase),
    .i_enable (in_mem_phase),
    .i_ready  (i_mem_ready),
    .o_expire (expire)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= FETCH;
      cause     <= CAUSE_NONE;
      o_retired <= '0;
    end else begin
      state <= state_nxt;
      if (cause_load) begin
        cause <= cause_nxt;
      end
      if (state == WB) begin
        o_retired <= o_retired + COUNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cause_nxt  = CAUSE_NONE;
    cause_load = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_we      = 1'b0;
    mdr_we     = 1'b0;
    rf_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = PC_PLUS4;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (i_mem_ready) begin
          ir_we     = 1'b1;
          state_nxt = DECODE;
        end else if (expire) begin
          state_nxt  = FAULT;
          cause_nxt  = CAUSE_TIMEOUT;
          cause_load = 1'b1;
        end
      end
      DECODE: begin
        if (is_legal_op(i_opcode)) begin
          state_nxt = EXECUTE;
        end else begin
          state_nxt  = FAULT;
          cause_nxt  = CAUSE_ILLEGAL;
          cause_load = 1'b1;
        end
      end
      EXECUTE: begin
        state_nxt = (i_load || i_mwrite) ? MEM : WB;
      end
      MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = i_mwrite;
        if (i_mem_ready) begin
          mdr_we    = i_load;
          state_nxt = WB;
        end else if (expire) begin
          state_nxt  = FAULT;
          cause_nxt  = CAUSE_TIMEOUT;
          cause_load = 1'b1;
        end
      end
      WB: begin
        rf_we = i_rwrite;
        pc_we = 1'b1;
        if (i_opcode[6:2] == OP_JAL ||
            (i_opcode[6:2] == OP_BRANCH && i_taken)) begin
          pc_sel = PC_IMM;
        end else if (i_opcode[6:2] == OP_JALR) begin
          pc_sel = PC_ALU;
        end
        state_nxt = FETCH;
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = FAULT;
      end
    endcase
  end

  // Reset forces FETCH, so the port would otherwise request during reset.
  assign o_mem_req     = mem_req  && !i_rst;
  assign o_mem_we      = mem_we   && !i_rst;
  assign o_addr_sel    = addr_sel && !i_rst;
  assign o_ir_we       = ir_we    && !i_rst;
  assign o_mdr_we      = mdr_we   && !i_rst;
  assign o_rf_we       = rf_we    && !i_rst;
  assign o_pc_we       = pc_we    && !i_rst;
  assign o_pc_sel      = pc_sel;
  assign o_fault       = (state == FAULT);
  assign o_fault_cause = cause;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: per-cycle expected output vectors
// are queued with the ready pattern, then replayed and compared.
module tb_core_sequencer;

  localparam int CW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [6:0]    i_opcode = 7'b0110011;
  logic          i_rwrite = 1'b0;
  logic          i_mwrite = 1'b0;
  logic          i_load = 1'b0;
  logic          i_taken = 1'b0;
  logic          i_mem_ready = 1'b0;
  logic          o_mem_req, o_mem_we, o_addr_sel, o_ir_we, o_mdr_we;
  logic          o_rf_we, o_pc_we, o_fault;
  logic [1:0]    o_pc_sel, o_fault_cause;
  logic [CW-1:0] o_retired;

  core_sequencer #(.MEM_TIMEOUT(4), .COUNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_rwrite(i_rwrite),
    .i_mwrite(i_mwrite), .i_load(i_load), .i_taken(i_taken),
    .i_mem_ready(i_mem_ready), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_addr_sel(o_addr_sel), .o_ir_we(o_ir_we), .o_mdr_we(o_mdr_we),
    .o_rf_we(o_rf_we), .o_pc_we(o_pc_we), .o_pc_sel(o_pc_sel),
    .o_retired(o_retired), .o_fault(o_fault), .o_fault_cause(o_fault_cause)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        ready;
    logic [11:0] vec;
  } step_t;

  step_t         sb[$];
  int            total = 0;
  int            bad = 0;
  logic [CW-1:0] exp_ret = '0;

  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] CUST = 7'b0001011;

  function automatic logic [11:0] obs();
    return {o_mem_req, o_mem_we, o_addr_sel, o_ir_we, o_mdr_we, o_rf_we,
            o_pc_we, o_pc_sel, o_fault, o_fault_cause};
  endfunction

  function automatic logic [11:0] mk(input logic req, we, as, ir, mdr, rf, pc,
                                     input logic [1:0] sel, input logic flt,
                                     input logic [1:0] cause);
    return {req, we, as, ir, mdr, rf, pc, sel, flt, cause};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Replays the queue; returns right after the compare of cycle stop_at.
  task automatic play(input string name, input int stop_at, output logic stopped);
    step_t s;
    int n;
    n = 0;
    stopped = 1'b0;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      i_mem_ready = s.ready;
      @(negedge i_clk);
      check_val($sformatf("%s c%0d", name, n), 32'(obs()), 32'(s.vec));
      if (n == stop_at) begin
        stopped = 1'b1;
        sb.delete();
        return;
      end
      @(posedge i_clk);
      #1;
      n++;
    end
  endtask

  task automatic run_instr(input string name, input logic [6:0] op,
                           input logic rw, mw, ld, tk,
                           input int fwait, mwait, stop_at);
    logic [1:0] sel;
    logic stopped;
    i_opcode = op; i_rwrite = rw; i_mwrite = mw; i_load = ld; i_taken = tk;
    sel = 2'b00;
    if (op[6:2] == 5'b11011 || (op[6:2] == 5'b11000 && tk)) sel = 2'b01;
    else if (op[6:2] == 5'b11001) sel = 2'b10;
    for (int k = 0; k < fwait; k++)
      sb.push_back('{ready: 1'b0, vec: mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00)});
    sb.push_back('{ready: 1'b1, vec: mk(1, 0, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00)});
    sb.push_back('{ready: 1'b1, vec: 12'h000});
    sb.push_back('{ready: 1'b1, vec: 12'h000});
    if (ld || mw) begin
      for (int k = 0; k < mwait; k++)
        sb.push_back('{ready: 1'b0, vec: mk(1, mw, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00)});
      sb.push_back('{ready: 1'b1, vec: mk(1, mw, 1, 0, ld, 0, 0, 2'b00, 0, 2'b00)});
    end
    sb.push_back('{ready: 1'b1, vec: mk(0, 0, 0, 0, 0, rw, 1, sel, 0, 2'b00)});
    play(name, stop_at, stopped);
    if (!stopped) begin
      exp_ret = exp_ret + 1'b1;
      check_val({name, " retired"}, 32'(o_retired), 32'(exp_ret));
    end
  endtask

  task automatic do_reset(input string name);
    i_rst = 1'b1;
    #1;
    check_val({name, " rst outputs"}, 32'(obs()), 32'h0);
    check_val({name, " rst retired"}, 32'(o_retired), 32'h0);
    exp_ret = '0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    logic stopped;
    #2;
    do_reset("init");

    run_instr("add",      ADD,  1, 0, 0, 0, 0, 0, -1);
    run_instr("lw",       LW,   1, 0, 1, 0, 0, 3, -1);
    run_instr("beq_t",    BEQ,  0, 0, 0, 1, 0, 0, -1);
    run_instr("beq_nt",   BEQ,  0, 0, 0, 0, 0, 0, -1);
    run_instr("sw",       SW,   0, 1, 0, 0, 1, 1, -1);
    run_instr("jal",      JAL,  1, 0, 0, 0, 0, 0, -1);
    run_instr("jalr",     JALR, 1, 0, 0, 1, 2, 0, -1);
    run_instr("lui",      LUI,  1, 0, 0, 0, 0, 0, -1);

    // store interrupted by reset while its data request is outstanding
    run_instr("sw_abort", SW,   0, 1, 0, 0, 0, 2, 3);
    do_reset("sw_abort");

    for (int i = 0; i < 16; i++)
      run_instr($sformatf("wrap%0d", i), ADD, 1, 0, 0, 0, 0, 0, -1);
    check_val("wrap zero", 32'(o_retired), 32'h0);

    i_opcode = CUST; i_rwrite = 1'b0; i_mwrite = 1'b0; i_load = 1'b0;
    sb.push_back('{ready: 1'b1, vec: mk(1, 0, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00)});
    sb.push_back('{ready: 1'b1, vec: 12'h000});
    for (int k = 0; k < 20; k++)
      sb.push_back('{ready: 1'b1, vec: mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b01)});
    play("illegal", -1, stopped);
    do_reset("illegal");
    i_mem_ready = 1'b0;
    @(negedge i_clk);
    check_val("post_rst fetch", 32'(obs()),
              32'(mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00)));
    @(posedge i_clk);
    #1;
    do_reset("pre_timeout");

    i_opcode = ADD; i_rwrite = 1'b1;
    for (int k = 0; k < 4; k++)
      sb.push_back('{ready: 1'b0, vec: mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00)});
    for (int k = 0; k < 3; k++)
      sb.push_back('{ready: 1'b1, vec: mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10)});
    play("timeout", -1, stopped);
    do_reset("timeout");

    run_instr("ready_last", ADD, 1, 0, 0, 0, 3, 0, -1);
    run_instr("mem_last",   LW,  1, 0, 1, 0, 0, 3, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
